// File: rtl/instr_buf_pkg.sv
// Shared types and default sizing for the instruction prefetch buffer.
package instr_buf_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_DEPTH = 4;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] instr;
  } instr_entry_t;

endpackage

// File: rtl/instr_prefetch_buffer.sv
// DEPTH-entry FIFO of fetched instructions tagged with their PC, with
// valid/ready on both sides and a synchronous flush for redirects.
module instr_prefetch_buffer
  import instr_buf_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [CW-1:0]   count
);

  localparam int PW = $clog2(DEPTH);

  // Same {pc, instr} layout as instr_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          full;

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !full && !flush;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  assign out_instr = out_valid ? mem[rd_ptr].instr : '0;
  assign out_pc    = out_valid ? mem[rd_ptr].pc    : '0;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer: expected entries queue on push
// and are compared against the head output when popped.
module tb_instr_prefetch_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [CW-1:0]   count;

  int checks = 0;
  int errors = 0;

  logic [2*XLEN-1:0] sb [$];

  instr_prefetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at posedge+1; drives one cycle, checks comb outputs at the
  // negedge, updates the model on the edge and checks count after it.
  task automatic step(input logic iv, input logic [XLEN-1:0] ins,
                      input logic [XLEN-1:0] pc, input logic ordy, input logic fl);
    logic exp_ready, do_push, do_pop;
    logic [XLEN-1:0] exp_instr, exp_pc;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    exp_ready = (sb.size() != DEPTH) && !fl;
    do_push   = iv && exp_ready;
    do_pop    = (sb.size() != 0) && ordy && !fl;
    exp_pc    = (sb.size() != 0) ? sb[0][2*XLEN-1:XLEN] : '0;
    exp_instr = (sb.size() != 0) ? sb[0][XLEN-1:0] : '0;
    @(negedge clk);
    checks++;
    if (in_ready !== exp_ready) begin
      errors++; $display("FAIL in_ready got %b exp %b", in_ready, exp_ready);
    end
    checks++;
    if (out_valid !== (sb.size() != 0)) begin
      errors++; $display("FAIL out_valid got %b exp %b", out_valid, sb.size() != 0);
    end
    checks++;
    if (out_pc !== exp_pc || out_instr !== exp_instr) begin
      errors++;
      $display("FAIL head got pc=%h instr=%h exp pc=%h instr=%h",
               out_pc, out_instr, exp_pc, exp_instr);
    end
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back({pc, ins});
    end
    #1;
    checks++;
    if (int'(count) !== sb.size()) begin
      errors++; $display("FAIL count got %0d exp %0d", count, sb.size());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_instr !== '0 || out_pc !== '0) begin
      errors++;
      $display("FAIL reset_held got count=%0d ov=%b instr=%h pc=%h exp 0/0/0/0",
               count, out_valid, out_instr, out_pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b count=%0d ov=%b exp 1/0/0",
               in_ready, count, out_valid);
    end
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_fill_full();
    step(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h0010_0093, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0113, 32'h8, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0193, 32'hC, 1'b0, 1'b0);
    checks++;
    if (count !== CW'(4)) begin
      errors++; $display("FAIL full_count got %0d exp 4", count);
    end
    // Fifth push plus a concurrent pop: a full buffer must still refuse.
    step(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_order_wrap();
    step(1'b1, 32'h0040_0213, 32'h10, 1'b0, 1'b0);
    step(1'b1, 32'h0050_0293, 32'h14, 1'b0, 1'b0);
    checks++;
    if (sb.size() != 4 || sb[0][2*XLEN-1:XLEN] != 32'h8) begin
      errors++; $display("FAIL wrap_setup got size=%0d exp 4 with head pc 8", sb.size());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h1000_0001, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h1000_0002, 32'h104, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h2000_0000 + i, 32'h108 + 4 * i, 1'b1, 1'b0);
    checks++;
    if (count !== CW'(2)) begin
      errors++; $display("FAIL b2b_count got %0d exp 2", count);
    end
    drain();
  endtask

  task automatic test_flush();
    step(1'b1, 32'h3000_0001, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h3000_0002, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'h3000_0003, 32'h208, 1'b0, 1'b0);
    step(1'b1, 32'hBAD0_0000, 32'h20C, 1'b1, 1'b1);
    idle(1);
    step(1'b1, 32'h3000_0010, 32'h300, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h4000_0001, 32'h400, 1'b0, 1'b0);
    step(1'b1, 32'h4000_0002, 32'h404, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_pc !== '0) begin
      errors++;
      $display("FAIL async_reset got count=%0d ov=%b pc=%h exp 0/0/0",
               count, out_valid, out_pc);
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 32'h4000_0003, 32'h408, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_fill_full();
    test_order_wrap();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
